aes_inv_key_sched: RTL and testbench

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_inv_key_step.sv | 33 +++
 rtl/aes_inv_key_sched.sv | 64 ++++++
 tb/tb_aes_inv_key_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES tables and types shared by the key-schedule
// and encrypt-side blocks.
package aes_pkg;

    typedef logic [127:0] key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed by round number; entries past round 10 are padding
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]],
                SBOX[w[15:8]],  SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: derives the round r-1 key from the
// round r key (pure combinational).
module aes_inv_key_step
    import aes_pkg::*;
(
    input  key_t       i_key,
    input  logic [3:0] i_round,
    output key_t       o_prev_key
);

    word_t w_a;
    word_t w_b;
    word_t w_c;
    word_t w_d;
    word_t w_an;
    word_t w_bn;
    word_t w_cn;
    word_t w_dn;

    assign {w_a, w_b, w_c, w_d} = i_key;

    // Undo the forward recurrence, last word first
    always_comb begin
        w_dn = w_d ^ w_c;
        w_cn = w_c ^ w_b;
        w_bn = w_b ^ w_a;
        w_an = w_a ^ sub_word(rot_word(w_dn))
                   ^ {RCON[i_round], 24'h0};
    end

    assign o_prev_key = {w_an, w_bn, w_cn, w_dn};

endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: streams AES-128 round keys 10 down to 0
// from the round-10 key, one key per output handshake.
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    input  logic [127:0] last_key,
    output logic         start_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy
);

    state_e     r_state;
    key_t       r_key;
    logic [3:0] r_round;
    key_t       w_prev_key;

    aes_inv_key_step u_step (
        .i_key      (r_key),
        .i_round    (r_round),
        .o_prev_key (w_prev_key)
    );

    // Accept a start in IDLE, then step backwards per handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_round <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_key   <= last_key;
                        r_round <= LAST_ROUND;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rk_ready) begin
                        if (r_round != 4'd0) begin
                            r_key   <= w_prev_key;
                            r_round <= r_round - 4'd1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign rk_valid    = (r_state == ST_RUN);
    assign busy        = (r_state == ST_RUN);
    assign rk_out      = r_key;
    assign rk_round    = r_round;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: directed checks of the inverse AES-128
// key schedule against a forward expansion computed here.
module tb_aes_inv_key_sched;
    import aes_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic [127:0] last_key;
    logic         start_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;

    int total;
    int bad;

    logic [127:0] exp_k [0:10];
    logic [127:0] got_k [0:10];
    logic [7:0]   rc [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_B    = 128'h00112233445566778899aabbccddeeff;

    aes_inv_key_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .last_key    (last_key),
        .start_ready (start_ready),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_out      (rk_out),
        .rk_round    (rk_round),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Forward key expansion; exp_k[r] is the round r key
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]],
                     SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Start with exp_k[10], collect all 11 keys; rnd stalls rk_ready
    task automatic run_seq(input bit rnd);
        int r;
        int cyc;
        @(negedge clk);
        last_key    = exp_k[10];
        start_valid = 1'b1;
        rk_ready    = 1'b0;
        @(negedge clk);
        start_valid = 1'b0;
        r   = 10;
        cyc = 0;
        while (r >= 0 && cyc < 300) begin
            chk("rk_valid", {127'd0, rk_valid}, 128'd1);
            chk("rk_round", {124'd0, rk_round}, 128'(r));
            chk("rk_out", rk_out, exp_k[r]);
            got_k[r] = rk_out;
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_ready) r--;
            cyc++;
            @(negedge clk);
        end
        chk("seq_done", 128'(r), -128'sd1);
        if (!rnd) chk("cycles", 128'(cyc), 128'd11);
        chk("idle_valid", {127'd0, rk_valid}, 128'd0);
        chk("idle_ready", {127'd0, start_ready}, 128'd1);
        chk("idle_hold", rk_out, exp_k[0]);
        rk_ready = 1'b0;
    endtask

    initial begin
        int n;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        last_key    = '0;
        rk_ready    = 1'b0;

        // Reset state
        #12;
        chk("rst_start_ready", {127'd0, start_ready}, 128'd1);
        chk("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_rk_out", rk_out, 128'd0);
        chk("rst_rk_round", {124'd0, rk_round}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 vector, rk_ready held high
        expand(K_FIPS);
        run_seq(1'b0);
        chk("fips_r10", got_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_r9", got_k[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips_r0", got_k[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("idle_round", {124'd0, rk_round}, 128'd0);

        // Same vector with random stalls
        run_seq(1'b1);
        run_seq(1'b1);

        // start_valid held high across a whole sequence
        @(negedge clk);
        last_key    = exp_k[10];
        start_valid = 1'b1;
        rk_ready    = 1'b1;
        @(negedge clk);
        last_key = K_B;
        for (int r = 10; r >= 0; r--) begin
            chk("hold_sr", {127'd0, start_ready}, 128'd0);
            chk("hold_busy", {127'd0, busy}, 128'd1);
            chk("hold_round", {124'd0, rk_round}, 128'(r));
            chk("hold_key", rk_out, exp_k[r]);
            @(negedge clk);
        end
        chk("gap_valid", {127'd0, rk_valid}, 128'd0);
        chk("gap_sr", {127'd0, start_ready}, 128'd1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("restart_valid", {127'd0, rk_valid}, 128'd1);
        chk("restart_round", {124'd0, rk_round}, 128'd10);
        chk("restart_key", rk_out, K_B);
        n = 0;
        while (rk_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {127'd0, rk_valid}, 128'd0);

        // Asynchronous reset at round 5
        expand(K_FIPS);
        @(negedge clk);
        last_key    = exp_k[10];
        start_valid = 1'b1;
        rk_ready    = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        n = 0;
        while (rk_round != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_r5", {124'd0, rk_round}, 128'd5);
        chk("r5_key", rk_out, exp_k[5]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", rk_out, 128'd0);
        chk("arst_round", {124'd0, rk_round}, 128'd0);
        chk("arst_valid", {127'd0, rk_valid}, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {127'd0, rk_valid}, 128'd0);
        end

        // Random keys through forward expansion
        for (int k = 0; k < 100; k++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            run_seq(k[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
